// File: rtl/fifo_rptr_empty_if.sv
// Read-side bus of the async FIFO pointer/status stage.
// Carries rerr_underflow only when RPTR_UNDERFLOW_ERR_EN is defined.
interface fifo_rptr_empty_if #(
   parameter int unsigned ADDR_WIDTH = 3
);
   logic                  rinc;
   logic [ADDR_WIDTH:0]   rq2_wptr;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [ADDR_WIDTH:0]   rptr;
   logic                  rempty;
   logic                  ralmost_empty;
   logic [ADDR_WIDTH:0]   rcount;
`ifdef RPTR_UNDERFLOW_ERR_EN
   logic                  rerr_underflow;

   modport master (
      output rinc, rq2_wptr,
      input  raddr, rptr, rempty, ralmost_empty, rcount, rerr_underflow
   );
   modport slave (
      input  rinc, rq2_wptr,
      output raddr, rptr, rempty, ralmost_empty, rcount, rerr_underflow
   );
`else
   modport master (
      output rinc, rq2_wptr,
      input  raddr, rptr, rempty, ralmost_empty, rcount
   );
   modport slave (
      input  rinc, rq2_wptr,
      output raddr, rptr, rempty, ralmost_empty, rcount
   );
`endif
endinterface

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer, empty/almost-empty flags and fill level of the async FIFO.
// Optional sticky underflow error output guarded by RPTR_UNDERFLOW_ERR_EN.
module fifo_rptr_empty #(
   parameter int unsigned ADDR_WIDTH    = 3,
   parameter int unsigned AEMPTY_THRESH = 1
) (
   input  logic              rclk,
   input  logic              rrstn,
   fifo_rptr_empty_if.slave  bus
);
   localparam int unsigned PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AeThresh = PW'(AEMPTY_THRESH);

   logic [PW-1:0] rbin_q, rbin_d;
   logic [PW-1:0] rptr_q, rgray_d;
   logic [PW-1:0] wbin_s, lvl_d;
   logic [PW-1:0] rcount_q;
   logic          rempty_q, ralmost_empty_q;
   logic          rd_ok;

   always_comb begin
      rd_ok   = bus.rinc & ~rempty_q;
      rbin_d  = rbin_q + PW'(rd_ok);
      rgray_d = (rbin_d >> 1) ^ rbin_d;
      // Gray to binary: each bit is the XOR of all Gray bits at or above it
      wbin_s  = '0;
      for (int i = 0; i < int'(PW); i++) begin
         wbin_s[i] = ^(bus.rq2_wptr >> i);
      end
      lvl_d   = wbin_s - rbin_d;
   end

   always_ff @(posedge rclk or negedge rrstn) begin
      if (!rrstn) begin
         rbin_q          <= '0;
         rptr_q          <= '0;
         rempty_q        <= 1'b1;
         ralmost_empty_q <= 1'b1;
         rcount_q        <= '0;
      end else begin
         rbin_q          <= rbin_d;
         rptr_q          <= rgray_d;
         rempty_q        <= (rgray_d == bus.rq2_wptr);
         ralmost_empty_q <= (lvl_d <= AeThresh);
         rcount_q        <= lvl_d;
      end
   end

   assign bus.raddr         = rbin_q[ADDR_WIDTH-1:0];
   assign bus.rptr          = rptr_q;
   assign bus.rempty        = rempty_q;
   assign bus.ralmost_empty = ralmost_empty_q;
   assign bus.rcount        = rcount_q;

`ifdef RPTR_UNDERFLOW_ERR_EN
   logic rerr_q;

   always_ff @(posedge rclk or negedge rrstn) begin
      if (!rrstn) begin
         rerr_q <= 1'b0;
      end else if (bus.rinc && rempty_q) begin
         rerr_q <= 1'b1;
      end
   end

   assign bus.rerr_underflow = rerr_q;
`endif
endmodule

// File: doc/fifo_rptr_empty.md
Name: fifo_rptr_empty

Overview:
Read-domain pointer and status stage of the asynchronous FIFO. It sits directly downstream of the write-to-read pointer synchronizer and consumes the synchronized Gray write pointer rq2_wptr. It produces:
- the binary RAM read address;
- the Gray read pointer rptr, which goes to the read-to-write synchronizer;
- registered empty, almost-empty and fill-level status, all in the rclk domain.

Parameters:
ADDR_WIDTH, 3, FIFO address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AEMPTY_THRESH, 1, ralmost_empty asserts when fill level <= this value; legal range 0..2^ADDR_WIDTH-1.

Ports:
rclk  input  1  read-domain clock; one clock only, all state updates on posedge rclk.
rrstn  input  1  asynchronous active-low reset.
rinc  input  1  read request from the consumer for this cycle.
rq2_wptr  input  ADDR_WIDTH+1  Gray write pointer, already synchronized into rclk.
raddr  output  ADDR_WIDTH  binary read address to the FIFO memory.
rptr  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
rempty  output  1  registered FIFO empty flag.
ralmost_empty  output  1  registered flag: fill level <= AEMPTY_THRESH.
rcount  output  ADDR_WIDTH+1  registered fill level, range 0..2^ADDR_WIDTH.

Behaviour:
- Reset (rrstn low, asynchronous): rbin=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rcount=0. Deassertion is taken synchronously to rclk upstream; no internal re-sync.
- Internal binary pointer rbin, ADDR_WIDTH+1 bits; raddr = rbin[ADDR_WIDTH-1:0], driven directly from the register.
- Read acceptance: rd_ok = rinc & ~rempty.
  - A read while rempty=1 is ignored: pointer, address and flags are unchanged.
- Next-state values (combinational):
  - rbin_next = rbin + rd_ok, modulo 2^(ADDR_WIDTH+1). Wraps from all-ones to 0 with no special case.
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
- Register update each posedge rclk: rbin<=rbin_next, rptr<=rgray_next.
  - rptr changes by at most one bit per cycle (Gray property). This is mandatory for the downstream synchronizer.
- Empty: rempty <= (rgray_next == rq2_wptr).
  - Empty asserts in the same edge as the read that consumes the last word. No one-cycle overshoot.
  - Empty deasserts one rclk after the updated rq2_wptr arrives. Total write-to-not-empty latency = 2 rclk of sync + 1 rclk flag register.
- Fill level:
  - wbin_s = Gray-to-binary of rq2_wptr: bit i = XOR of rq2_wptr[ADDR_WIDTH:i].
  - lvl_next = wbin_s - rbin_next, modulo 2^(ADDR_WIDTH+1).
  - rcount <= lvl_next.
  - ralmost_empty <= (lvl_next <= AEMPTY_THRESH).
  - rempty and (lvl_next==0) must always agree. Any mismatch is a design error; the bench checks it every cycle.
- Pessimism: status flags are conservative, since rq2_wptr lags the true write pointer.
  - rcount may under-report but never over-report.
  - rempty may be stale-high, never stale-low.
- Simultaneous read with write-pointer advance in the same cycle: both are applied. lvl_next reflects both, so the net fill level is unchanged.
- Full FIFO seen from the read side (lvl_next = 2^ADDR_WIDTH): rcount = 2^ADDR_WIDTH (MSB set, lower bits 0). rempty=0.
- Reset asserted mid-operation: all outputs return immediately to their reset values. Any rinc during reset is discarded.

Optional Feature:
Macro RPTR_UNDERFLOW_ERR_EN.
- Defined:
  - Adds output rerr_underflow (1 bit, reset 0).
  - Set sticky on any posedge where rinc=1 and rempty=1.
  - Cleared only by rrstn.
- Not defined:
  - Port and logic are absent.
  - Reads while empty are silently ignored, exactly as described above.

Test Plan (ADDR_WIDTH=3, AEMPTY_THRESH=1):
1. Reset check: hold rrstn low, toggle rinc -> rempty=1, ralmost_empty=1, rptr=0, raddr=0, rcount=0. Release -> values hold while rq2_wptr=0.
2. Fill then drain: drive rq2_wptr=4'b0110 (binary 4), then no rinc for one cycle -> rcount=4, rempty=0, ralmost_empty=0. Then rinc for 4 cycles -> rcount 3,2,1,0; ralmost_empty rises with rcount=1; rempty rises on the edge of the 4th read; raddr sequence 0,1,2,3,4.
3. Underflow: with rempty=1, pulse rinc for 3 cycles -> rptr, raddr, rcount unchanged. With RPTR_UNDERFLOW_ERR_EN, rerr_underflow=1 and stays 1 until reset.
4. Wrap-around: stream 20 writes and reads, moving rq2_wptr one Gray step ahead each cycle with rinc=1 -> rbin passes 15->0. rptr sequence matches the Gray code with exactly one bit change per step. rempty never asserts while rq2_wptr != rptr. rcount stays 1.
5. Full read side: rq2_wptr=4'b1100 (binary 8) with rbin=0 -> rcount=8, rempty=0, ralmost_empty=0.
6. Mid-operation reset: at rcount=5, rbin=3, assert rrstn asynchronously between clock edges -> all outputs reach their reset values before the next rclk edge.
